stream_in_port: RTL and testbench

- AXI4-Stream video slave front end for the VDMA write path; the receive-side counterpart of the stream output port.
- Accepts pixels framed by tuser (start of frame) and tlast (end of line), and writes them into the write-side FIFO.
- Generates the frame, line and end alignment pulses the write DMA controller needs, and checks line/frame geometry against hactive/vactive.

---
 rtl/stream_in_port.sv | 141 ++++++++++++++
 tb/tb_stream_in_port.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_in_port.sv
// AXI4-Stream video slave front end for the VDMA write path: frames pixels into the write FIFO,
// generates frame/line/end alignment pulses and checks geometry. Optional error counter: STREAM_IN_ERR_CNT_EN.
module stream_in_port #(
  parameter int DSIZE = 24,
  parameter     MODE  = "ONCE"
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic [DSIZE-1:0] axi_tdata,
  input  logic             axi_tvalid,
  output logic             axi_tready,
  input  logic             axi_tuser,
  input  logic             axi_tlast,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [DSIZE-1:0] wr_data,
  output logic             falign,
  output logic             lalign,
  output logic             ealign,
  output logic             line_err,
  output logic             sof_err,
`ifdef STREAM_IN_ERR_CNT_EN
  output logic [15:0]      err_cnt,
`endif
  output logic             frame_busy
);

  localparam bit LINE_MODE = (MODE == "LINE");

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [15:0] r_pcnt;
  logic [15:0] r_lcnt;
  logic [15:0] r_hact;
  logic [15:0] r_vact;

  logic        w_beat;
  logic        w_sof;
  logic        w_sofErr;
  logic        w_write;
  logic        w_last;
  logic        w_lineErr;
  logic        w_frameEnd;
  logic [15:0] w_pcur;
  logic [15:0] w_lcur;
  logic [15:0] w_hact;
  logic [15:0] w_vact;
  logic [16:0] w_pnext;
  logic [16:0] w_lnext;

  // An SOF beat restarts the geometry, so the current position and sizes come from the beat itself.
  assign w_beat     = axi_tvalid && axi_tready;
  assign w_sof      = w_beat && axi_tuser;
  assign w_sofErr   = w_sof && (r_state == ACTIVE);
  assign w_write    = w_beat && ((r_state == ACTIVE) || axi_tuser);
  assign w_pcur     = w_sof ? 16'd0 : r_pcnt;
  assign w_lcur     = w_sof ? 16'd0 : r_lcnt;
  assign w_hact     = w_sof ? hactive : r_hact;
  assign w_vact     = w_sof ? ((vactive == 16'd0) ? 16'd1 : vactive) : r_vact;
  assign w_pnext    = {1'b0, w_pcur} + 17'd1;
  assign w_lnext    = {1'b0, w_lcur} + 17'd1;
  assign w_last     = w_write && axi_tlast;
  assign w_lineErr  = w_last && (w_pnext != {1'b0, w_hact});
  assign w_frameEnd = w_last && (w_lnext == {1'b0, w_vact});

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_state <= WAIT_SOF;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_frameEnd)  w_stateNext = WAIT_SOF;
    else if (w_sof)  w_stateNext = ACTIVE;
  end

  always_comb begin
    axi_tready = 1'b0;
    frame_busy = (r_state == ACTIVE);
    if (!rst) axi_tready = (r_state == ACTIVE) ? ~fifo_full : 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_lcnt <= '0;
      r_hact <= '0;
      r_vact <= '0;
    end else if (w_write) begin
      if (w_sof) begin
        r_hact <= w_hact;
        r_vact <= w_vact;
      end
      if (w_last) begin
        r_pcnt <= '0;
        r_lcnt <= w_frameEnd ? 16'd0 : w_lnext[15:0];
      end else begin
        r_pcnt <= (w_pcur == 16'hFFFF) ? 16'hFFFF : w_pnext[15:0];
        r_lcnt <= w_lcur;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_data  <= '0;
      falign   <= 1'b0;
      lalign   <= 1'b0;
      ealign   <= 1'b0;
      line_err <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      wr_en    <= w_write;
      if (w_write) wr_data <= axi_tdata;
      falign   <= w_sof;
      lalign   <= LINE_MODE && w_last;
      ealign   <= w_frameEnd;
      line_err <= w_lineErr;
      sof_err  <= w_sofErr;
    end
  end

`ifdef STREAM_IN_ERR_CNT_EN
  logic [16:0] w_errSum;

  // Both error kinds can fire on one beat, so the sum is widened before saturating.
  assign w_errSum = {1'b0, err_cnt} + {16'd0, w_lineErr} + {16'd0, w_sofErr};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= w_errSum[16] ? 16'hFFFF : w_errSum[15:0];
  end
`endif

endmodule

// File: tb/tb_stream_in_port.sv
// Self-checking bench for stream_in_port: directed frames plus randomized traffic against a
// frame/line/pixel reference model; ONCE and LINE instances share all inputs.
module tb_stream_in_port;

  localparam int DSIZE = 24;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      vactive = '0;
  logic [15:0]      hactive = '0;
  logic [DSIZE-1:0] tdata = '0;
  logic             tvalid = 1'b0;
  logic             tuser = 1'b0;
  logic             tlast = 1'b0;
  logic             fifoFull = 1'b0;

  logic             tready0, wrEn0, falign0, lalign0, ealign0, lineErr0, sofErr0, busy0;
  logic             tready1, wrEn1, falign1, lalign1, ealign1, lineErr1, sofErr1, busy1;
  logic [DSIZE-1:0] wrData0, wrData1;
`ifdef STREAM_IN_ERR_CNT_EN
  logic [15:0]      errCnt0, errCnt1;
`endif

  int tests = 0;
  int failures = 0;

  // reference model state
  bit mInFrame = 0;
  int mPix = 0, mLine = 0, mH = 0, mV = 1, mWr = 0;
  bit mBeat = 0;
  bit eWr = 0, eF = 0, eLL = 0, eE = 0, eLE = 0, eSE = 0;
  logic [DSIZE-1:0] eData = '0;
  int eErr = 0;

  // tallies of observed DUT events
  int cntWr = 0, cntF = 0, cntE = 0, cntLE = 0, cntSE = 0, cntLL = 0, cntLO = 0;
  logic [DSIZE-1:0] capData[$];
  int bWr, bF, bE, bLE, bSE, bLL, bLO, bCap, bErr;
  bit togglePhase = 0;

  stream_in_port #(.DSIZE(DSIZE), .MODE("ONCE")) dutOnce (
    .clock(clock), .rst(rst), .vactive(vactive), .hactive(hactive),
    .axi_tdata(tdata), .axi_tvalid(tvalid), .axi_tready(tready0),
    .axi_tuser(tuser), .axi_tlast(tlast), .fifo_full(fifoFull),
    .wr_en(wrEn0), .wr_data(wrData0), .falign(falign0), .lalign(lalign0),
    .ealign(ealign0), .line_err(lineErr0), .sof_err(sofErr0),
`ifdef STREAM_IN_ERR_CNT_EN
    .err_cnt(errCnt0),
`endif
    .frame_busy(busy0)
  );

  stream_in_port #(.DSIZE(DSIZE), .MODE("LINE")) dutLine (
    .clock(clock), .rst(rst), .vactive(vactive), .hactive(hactive),
    .axi_tdata(tdata), .axi_tvalid(tvalid), .axi_tready(tready1),
    .axi_tuser(tuser), .axi_tlast(tlast), .fifo_full(fifoFull),
    .wr_en(wrEn1), .wr_data(wrData1), .falign(falign1), .lalign(lalign1),
    .ealign(ealign1), .line_err(lineErr1), .sof_err(sofErr1),
`ifdef STREAM_IN_ERR_CNT_EN
    .err_cnt(errCnt1),
`endif
    .frame_busy(busy1)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted beat is interpreted in frame/line/pixel terms; results are what the outputs show next cycle.
  always @(posedge clock) begin
    bit ready;
    mBeat = 0; eWr = 0; eF = 0; eLL = 0; eE = 0; eLE = 0; eSE = 0;
    if (rst) begin
      mInFrame = 0; mPix = 0; mLine = 0; eErr = 0;
    end else begin
      ready = mInFrame ? !fifoFull : 1'b1;
      if (tvalid && ready) begin
        mBeat = 1;
        if (tuser) begin
          eF = 1; eSE = mInFrame; mInFrame = 1;
          mPix = 0; mLine = 0; mH = int'(hactive);
          mV = (vactive == 16'd0) ? 1 : int'(vactive);
        end
        if (mInFrame) begin
          eWr = 1; eData = tdata; mWr++;
          if (tlast) begin
            eLE = (mPix + 1 != mH); eLL = 1; mLine++; mPix = 0;
            if (mLine == mV) begin eE = 1; mInFrame = 0; end
          end else if (mPix < 65535) begin
            mPix++;
          end
        end
        eErr = eErr + int'(eLE) + int'(eSE);
        if (eErr > 65535) eErr = 65535;
      end
    end
  end

  // Compare process: outputs are checked mid-cycle, well away from the active edge.
  always @(negedge clock) begin
    bit expReady;
    expReady = rst ? 1'b0 : (mInFrame ? !fifoFull : 1'b1);
    checkOutput("tready", 32'(tready0), 32'(expReady));
    checkOutput("tready_line", 32'(tready1), 32'(expReady));
    checkOutput("wr_en", 32'(wrEn0), 32'(eWr));
    checkOutput("wr_en_line", 32'(wrEn1), 32'(eWr));
    if (eWr) begin
      checkOutput("wr_data", 32'(wrData0), 32'(eData));
      checkOutput("wr_data_line", 32'(wrData1), 32'(eData));
    end
    checkOutput("falign", 32'(falign0), 32'(eF));
    checkOutput("lalign_once", 32'(lalign0), 32'd0);
    checkOutput("lalign_line", 32'(lalign1), 32'(eLL));
    checkOutput("ealign", 32'(ealign0), 32'(eE));
    checkOutput("line_err", 32'(lineErr0), 32'(eLE));
    checkOutput("sof_err", 32'(sofErr0), 32'(eSE));
    checkOutput("frame_busy", 32'(busy0), 32'(mInFrame && !rst));
`ifdef STREAM_IN_ERR_CNT_EN
    checkOutput("err_cnt", 32'(errCnt0), 32'(eErr));
    checkOutput("err_cnt_line", 32'(errCnt1), 32'(eErr));
`endif
    if (wrEn0) begin cntWr++; capData.push_back(wrData0); end
    if (falign0)  cntF++;
    if (ealign0)  cntE++;
    if (lineErr0) cntLE++;
    if (sofErr0)  cntSE++;
    if (lalign1)  cntLL++;
    if (lalign0)  cntLO++;
  end

  // Drives one cycle of inputs, then returns just after the edge that samples them.
  task automatic applyStimulus(input bit v, input logic [DSIZE-1:0] d, input bit u, input bit l, input bit f);
    tvalid = v; tdata = d; tuser = u; tlast = l; fifoFull = f;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, 0);
  endtask

  // Holds one pixel until the model accepts it; optionally toggles fifo_full every attempt.
  task automatic sendPixel(input logic [DSIZE-1:0] d, input bit u, input bit l, input bit toggleFull);
    bit done;
    bit f;
    done = 0;
    for (int k = 0; k < 16 && !done; k++) begin
      f = toggleFull ? togglePhase : 1'b0;
      togglePhase = ~togglePhase;
      applyStimulus(1, d, u, l, f);
      done = mBeat;
    end
    if (!done) begin
      tests++; failures++;
      $display("[TB] FAIL send_timeout: pixel 0x%0h not accepted, required acceptance", d);
    end
  endtask

  task automatic sendFrame8(input logic [DSIZE-1:0] base, input bit toggleFull);
    for (int i = 0; i < 8; i++) sendPixel(base + DSIZE'(i), i == 0, (i == 3) || (i == 7), toggleFull);
  endtask

  task automatic mark();
    bWr = cntWr; bF = cntF; bE = cntE; bLE = cntLE; bSE = cntSE; bLL = cntLL; bLO = cntLO;
    bCap = capData.size(); bErr = eErr;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    idle(2);

    // 4x2 frame, continuous valid
    hactive = 16'd4; vactive = 16'd2;
    mark();
    sendFrame8(24'h000100, 0);
    idle(2);
    checkOutput("t1_writes", 32'(cntWr - bWr), 32'd8);
    checkOutput("t1_falign", 32'(cntF - bF), 32'd1);
    checkOutput("t1_ealign", 32'(cntE - bE), 32'd1);
    checkOutput("t1_line_err", 32'(cntLE - bLE), 32'd0);
    checkOutput("t1_lalign_line", 32'(cntLL - bLL), 32'd2);
    checkOutput("t1_lalign_once", 32'(cntLO - bLO), 32'd0);
    for (int i = 0; i < 8; i++) checkOutput("t1_data", 32'(capData[bCap + i]), 32'h100 + 32'(i));

    // beats before SOF are dropped
    mark();
    for (int i = 0; i < 3; i++) applyStimulus(1, 24'h000200 + 24'(i), 0, 0, 0);
    sendFrame8(24'h000300, 0);
    idle(2);
    checkOutput("t2_writes", 32'(cntWr - bWr), 32'd8);
    checkOutput("t2_first", 32'(capData[bCap]), 32'h300);

    // short first line
    mark();
    sendPixel(24'h000400, 1, 0, 0);
    sendPixel(24'h000401, 0, 0, 0);
    sendPixel(24'h000402, 0, 1, 0);
    for (int i = 0; i < 4; i++) sendPixel(24'h000410 + 24'(i), 0, i == 3, 0);
    idle(2);
    checkOutput("t3_writes", 32'(cntWr - bWr), 32'd7);
    checkOutput("t3_line_err", 32'(cntLE - bLE), 32'd1);
    checkOutput("t3_ealign", 32'(cntE - bE), 32'd1);

    // SOF injected at line 1, pixel 2
    mark();
    for (int i = 0; i < 4; i++) sendPixel(24'h000500 + 24'(i), i == 0, i == 3, 0);
    sendPixel(24'h000510, 0, 0, 0);
    sendPixel(24'h000511, 0, 0, 0);
    sendFrame8(24'h000520, 0);
    idle(2);
    checkOutput("t4_sof_err", 32'(cntSE - bSE), 32'd1);
    checkOutput("t4_falign", 32'(cntF - bF), 32'd2);
    checkOutput("t4_ealign", 32'(cntE - bE), 32'd1);
    checkOutput("t4_writes", 32'(cntWr - bWr), 32'd14);

    // fifo_full toggling every cycle
    mark();
    sendFrame8(24'h000600, 1);
    idle(2);
    checkOutput("t5_writes", 32'(cntWr - bWr), 32'd8);
    for (int i = 0; i < 8; i++) checkOutput("t5_data", 32'(capData[bCap + i]), 32'h600 + 32'(i));

    // 1x1 frame: tuser and tlast together
    hactive = 16'd1; vactive = 16'd1;
    mark();
    sendPixel(24'h000700, 1, 1, 0);
    idle(2);
    checkOutput("t6_falign", 32'(cntF - bF), 32'd1);
    checkOutput("t6_ealign", 32'(cntE - bE), 32'd1);
    checkOutput("t6_line_err", 32'(cntLE - bLE), 32'd0);

    // hactive=0 flags every tlast, vactive=0 behaves as 1
    hactive = 16'd0; vactive = 16'd0;
    mark();
    sendPixel(24'h000800, 1, 1, 0);
    idle(2);
    checkOutput("t7_line_err", 32'(cntLE - bLE), 32'd1);
    checkOutput("t7_ealign", 32'(cntE - bE), 32'd1);

    // one short line plus one early SOF
    hactive = 16'd4; vactive = 16'd2;
    mark();
    sendPixel(24'h000900, 1, 0, 0);
    sendPixel(24'h000901, 0, 1, 0);
    sendPixel(24'h000902, 0, 0, 0);
    sendFrame8(24'h000910, 0);
    idle(2);
    checkOutput("t8_errors", 32'((cntLE - bLE) + (cntSE - bSE)), 32'd2);
`ifdef STREAM_IN_ERR_CNT_EN
    checkOutput("t8_err_cnt", 32'(errCnt0) - 32'(bErr), 32'd2);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        hactive = 16'($urandom_range(0, 5));
        vactive = 16'($urandom_range(0, 3));
      end
      applyStimulus($urandom_range(0, 3) != 0, DSIZE'($urandom), $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    idle(3);
    checkOutput("total_writes", 32'(cntWr), 32'(mWr));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
